// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit character-LCD bus: control bit positions,
// HD44780 command opcodes/masks, bus modes and nibble phases.
package lcd_pkg;

  localparam int unsigned SHADOW_DEPTH = 32;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned NIB_W        = 4;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned CTRL_W       = 3;

  localparam int unsigned CTRL_RS = 2;
  localparam int unsigned CTRL_RW = 1;
  localparam int unsigned CTRL_E  = 0;

  // A command matches when (byte & mask) == opcode
  localparam logic [BYTE_W-1:0] CMD_SET_DDRAM      = 8'h80;
  localparam logic [BYTE_W-1:0] CMD_SET_DDRAM_MASK = 8'h80;
  localparam logic [BYTE_W-1:0] CMD_FUNC_SET       = 8'h20;
  localparam logic [BYTE_W-1:0] CMD_FUNC_SET_MASK  = 8'hE0;
  localparam logic [BYTE_W-1:0] CMD_DISP_CTRL      = 8'h08;
  localparam logic [BYTE_W-1:0] CMD_DISP_CTRL_MASK = 8'hF8;
  localparam logic [BYTE_W-1:0] CMD_ENTRY_MODE     = 8'h04;
  localparam logic [BYTE_W-1:0] CMD_ENTRY_MASK     = 8'hFC;
  localparam logic [BYTE_W-1:0] CMD_HOME           = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_HOME_MASK      = 8'hFE;
  localparam logic [BYTE_W-1:0] CMD_CLEAR          = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_CLEAR_MASK     = 8'hFF;

  localparam logic [NIB_W-1:0] NIB_FUNC_4BIT = 4'h2;

  typedef enum logic {M8 = 1'b0, M4 = 1'b1} mode_e;
  typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_e;

  function automatic logic cmd_match(input logic [BYTE_W-1:0] b,
                                     input logic [BYTE_W-1:0] mask,
                                     input logic [BYTE_W-1:0] op);
    return (b & mask) == op;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the LCD nibble bus into clk_in and strobes on E falling edges,
// presenting RS/RW/nibble aligned with the strobe.
module lcd_bus_sync
  import lcd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              nClear,
  input  logic [NIB_W-1:0]  i_nib,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_stb_c,
  output logic              o_rs,
  output logic              o_rw,
  output logic [NIB_W-1:0]  o_nib
);

  localparam int unsigned BUS_W = NIB_W + CTRL_W;

  logic [BUS_W-1:0] r_sync [SYNC_STAGES];
  logic             r_e_d;
  logic [BUS_W-1:0] w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in) begin
    if (!nClear) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_e_d <= 1'b0;
    end else begin
      r_sync[0] <= {i_ctrl, i_nib};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_e_d <= w_last[NIB_W+CTRL_E];
    end
  end

  assign o_stb_c = r_e_d & ~w_last[NIB_W+CTRL_E];
  assign o_rs    = w_last[NIB_W+CTRL_RS];
  assign o_rw    = w_last[NIB_W+CTRL_RW];
  assign o_nib   = w_last[NIB_W-1:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Receiving end of the 4-bit LCD bus: assembles nibbles into bytes, decodes
// the HD44780 command subset and keeps a 32-character display shadow.
module lcd_bus_monitor
  import lcd_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] CLEAR_CHAR  = 8'h20
) (
  input  logic              clk_in,
  input  logic              nClear,
  input  logic [NIB_W-1:0]  lcd_data,
  input  logic [CTRL_W-1:0] lcd_ctrl,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BYTE_W-1:0] rd_char,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_rs,
  output logic [ADDR_W-1:0] cursor,
  output logic              disp_on,
  output logic              busy,
  output logic              err
);

  logic              w_stb_c;
  logic              w_rs;
  logic              w_rw;
  logic [NIB_W-1:0]  w_nib;
  logic              w_take;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in  (clk_in),
    .nClear  (nClear),
    .i_nib   (lcd_data),
    .i_ctrl  (lcd_ctrl),
    .o_stb_c (w_stb_c),
    .o_rs    (w_rs),
    .o_rw    (w_rw),
    .o_nib   (w_nib)
  );

  assign w_take = w_stb_c & ~w_rw;

  mode_e             r_mode,     w_mode_nxt;
  phase_e            r_phase,    w_phase_nxt;
  logic [NIB_W-1:0]  r_hi,       w_hi_nxt;
  logic              r_bv,       w_bv_nxt;
  logic [BYTE_W-1:0] r_byte,     w_byte_nxt;
  logic              r_rs,       w_rs_nxt;
  logic [ADDR_W-1:0] r_cursor,   w_cursor_nxt;
  logic              r_id,       w_id_nxt;
  logic              r_disp_on,  w_disp_on_nxt;
  logic              r_busy,     w_busy_nxt;
  logic [ADDR_W-1:0] r_clr_cnt,  w_clr_cnt_nxt;
  logic              r_err,      w_err_nxt;
  logic [BYTE_W-1:0] r_rd_char;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [BYTE_W-1:0] w_wr_data;

  logic [BYTE_W-1:0] r_shadow [SHADOW_DEPTH];

  // Next-state: clear sequencing, byte execution, then nibble assembly
  always_comb begin
    w_mode_nxt    = r_mode;
    w_phase_nxt   = r_phase;
    w_hi_nxt      = r_hi;
    w_bv_nxt      = 1'b0;
    w_byte_nxt    = r_byte;
    w_rs_nxt      = r_rs;
    w_cursor_nxt  = r_cursor;
    w_id_nxt      = r_id;
    w_disp_on_nxt = r_disp_on;
    w_busy_nxt    = r_busy;
    w_clr_cnt_nxt = r_clr_cnt;
    w_err_nxt     = r_err;
    w_wr_en       = 1'b0;
    w_wr_addr     = r_cursor;
    w_wr_data     = r_byte;

    if (r_busy) begin
      w_wr_en       = 1'b1;
      w_wr_addr     = r_clr_cnt;
      w_wr_data     = CLEAR_CHAR;
      w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
      if (r_clr_cnt == ADDR_W'(SHADOW_DEPTH - 1)) w_busy_nxt = 1'b0;
    end

    // The decoded byte executes on the edge that ends its byte_valid cycle
    if (r_bv) begin
      if (r_busy) begin
        w_err_nxt = 1'b1;
      end else if (r_rs) begin
        w_wr_en      = 1'b1;
        w_wr_addr    = r_cursor;
        w_wr_data    = r_byte;
        w_cursor_nxt = r_id ? r_cursor + ADDR_W'(1) : r_cursor - ADDR_W'(1);
      end else if (cmd_match(r_byte, CMD_SET_DDRAM_MASK, CMD_SET_DDRAM)) begin
        w_cursor_nxt = {r_byte[6], r_byte[3:0]};
      end else if (cmd_match(r_byte, CMD_FUNC_SET_MASK, CMD_FUNC_SET)) begin
        if (r_byte[4]) begin
          w_mode_nxt  = M8;
          w_phase_nxt = PH_HI;
        end
      end else if (cmd_match(r_byte, CMD_DISP_CTRL_MASK, CMD_DISP_CTRL)) begin
        w_disp_on_nxt = r_byte[2];
      end else if (cmd_match(r_byte, CMD_ENTRY_MASK, CMD_ENTRY_MODE)) begin
        w_id_nxt = r_byte[1];
      end else if (cmd_match(r_byte, CMD_HOME_MASK, CMD_HOME)) begin
        w_cursor_nxt = '0;
      end else if (cmd_match(r_byte, CMD_CLEAR_MASK, CMD_CLEAR)) begin
        w_cursor_nxt  = '0;
        w_id_nxt      = 1'b1;
        w_busy_nxt    = 1'b1;
        w_clr_cnt_nxt = '0;
      end
    end

    if (w_take) begin
      if (r_mode == M8) begin
        if (w_nib == NIB_FUNC_4BIT && !w_rs) begin
          w_mode_nxt  = M4;
          w_phase_nxt = PH_HI;
        end
      end else if (r_phase == PH_HI) begin
        w_hi_nxt    = w_nib;
        w_phase_nxt = PH_LO;
      end else begin
        w_byte_nxt  = {r_hi, w_nib};
        w_rs_nxt    = w_rs;
        w_bv_nxt    = 1'b1;
        w_phase_nxt = PH_HI;
      end
    end
  end

  // Reset arms a full clear from address 0
  always_ff @(posedge clk_in) begin
    if (!nClear) begin
      r_mode    <= M8;
      r_phase   <= PH_HI;
      r_hi      <= '0;
      r_bv      <= 1'b0;
      r_byte    <= '0;
      r_rs      <= 1'b0;
      r_cursor  <= '0;
      r_id      <= 1'b1;
      r_disp_on <= 1'b0;
      r_busy    <= 1'b1;
      r_clr_cnt <= '0;
      r_err     <= 1'b0;
      r_rd_char <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_phase   <= w_phase_nxt;
      r_hi      <= w_hi_nxt;
      r_bv      <= w_bv_nxt;
      r_byte    <= w_byte_nxt;
      r_rs      <= w_rs_nxt;
      r_cursor  <= w_cursor_nxt;
      r_id      <= w_id_nxt;
      r_disp_on <= w_disp_on_nxt;
      r_busy    <= w_busy_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_err     <= w_err_nxt;
      r_rd_char <= r_shadow[rd_addr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (nClear && w_wr_en) r_shadow[w_wr_addr] <= w_wr_data;
  end

  assign rd_char    = r_rd_char;
  assign byte_valid = r_bv;
  assign byte_out   = r_byte;
  assign byte_rs    = r_rs;
  assign cursor     = r_cursor;
  assign disp_on    = r_disp_on;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule
